// File: rtl/dsg_pkg.sv
// Shared types and widths for the multichannel signal generator and its
// measurement-side counterpart.
package dsg_pkg;
  localparam int TIME_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } dsg_state_t;
endpackage

// File: rtl/digital_signal_generate.sv
// One generator channel: square wave with latched high/low durations,
// repeated for a programmed number of periods or continuously.
module digital_signal_generate
  import dsg_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gen_start,
  input  logic              gen_stop,
  input  logic [TIME_W-1:0] high_time,
  input  logic [TIME_W-1:0] low_time,
  input  logic [TIME_W-1:0] pulse_count,
  output logic              gen_pin,
  output logic              gen_busy,
  output logic              gen_done
);
  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  dsg_state_t        state;
  logic [TIME_W-1:0] h_lat;
  logic [TIME_W-1:0] l_lat;
  logic [TIME_W-1:0] n_lat;
  logic [TIME_W-1:0] phase_cnt;
  logic [TIME_W-1:0] period_cnt;
  logic              start_ok;
  logic              last_period;

  assign start_ok = gen_start && !gen_stop && (high_time != '0) && (low_time != '0);
  // Comparing against N-1 before incrementing keeps N=65535 free of wrap issues.
  assign last_period = (n_lat != '0) && (period_cnt == n_lat - ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      h_lat      <= '0;
      l_lat      <= '0;
      n_lat      <= '0;
      phase_cnt  <= '0;
      period_cnt <= '0;
      gen_pin    <= 1'b0;
      gen_busy   <= 1'b0;
      gen_done   <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            h_lat      <= high_time;
            l_lat      <= low_time;
            n_lat      <= pulse_count;
            phase_cnt  <= high_time - ONE;
            period_cnt <= '0;
            state      <= HIGH;
            gen_pin    <= 1'b1;
            gen_busy   <= 1'b1;
          end
        end
        HIGH: begin
          if (gen_stop) begin
            state    <= IDLE;
            gen_pin  <= 1'b0;
            gen_busy <= 1'b0;
          end else if (phase_cnt == '0) begin
            state     <= LOW;
            phase_cnt <= l_lat - ONE;
            gen_pin   <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        LOW: begin
          if (gen_stop) begin
            state    <= IDLE;
            gen_pin  <= 1'b0;
            gen_busy <= 1'b0;
          end else if (phase_cnt == '0) begin
            if (last_period) begin
              state    <= IDLE;
              gen_busy <= 1'b0;
              gen_done <= 1'b1;
            end else begin
              state      <= HIGH;
              phase_cnt  <= h_lat - ONE;
              period_cnt <= period_cnt + ONE;
              gen_pin    <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end
        default: begin
          state    <= IDLE;
          gen_pin  <= 1'b0;
          gen_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/dsg_multichannel.sv
// Array of independent square-wave generator channels with packed
// per-channel timing fields.
module dsg_multichannel
  import dsg_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int TIME_W       = TIME_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHANNELS-1:0]        gen_start,
  input  logic [NUM_CHANNELS-1:0]        gen_stop,
  input  logic [NUM_CHANNELS*TIME_W-1:0] high_time,
  input  logic [NUM_CHANNELS*TIME_W-1:0] low_time,
  input  logic [NUM_CHANNELS*TIME_W-1:0] pulse_count,
  output logic [NUM_CHANNELS-1:0]        gen_pin,
  output logic [NUM_CHANNELS-1:0]        gen_busy,
  output logic [NUM_CHANNELS-1:0]        gen_done
);
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    digital_signal_generate #(
      .TIME_W(TIME_W)
    ) u_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .gen_start  (gen_start[ch]),
      .gen_stop   (gen_stop[ch]),
      .high_time  (high_time[ch*TIME_W +: TIME_W]),
      .low_time   (low_time[ch*TIME_W +: TIME_W]),
      .pulse_count(pulse_count[ch*TIME_W +: TIME_W]),
      .gen_pin    (gen_pin[ch]),
      .gen_busy   (gen_busy[ch]),
      .gen_done   (gen_done[ch])
    );
  end
endmodule

// File: tb/tb_dsg_multichannel.sv
// Bench for dsg_multichannel: closed-form waveform predictor feeding a
// per-cycle scoreboard, a table of single-run vectors, and corner sequences.
module tb_dsg_multichannel;
  localparam int NCH = 8;
  localparam int TW  = 16;
  localparam int NEVER = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    gen_start, gen_stop;
  logic [NCH*TW-1:0] high_time, low_time, pulse_count;
  logic [NCH-1:0]    gen_pin, gen_busy, gen_done;

  always #5 clk = ~clk;

  dsg_multichannel #(.NUM_CHANNELS(NCH), .TIME_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .gen_start(gen_start), .gen_stop(gen_stop),
    .high_time(high_time), .low_time(low_time), .pulse_count(pulse_count),
    .gen_pin(gen_pin), .gen_busy(gen_busy), .gen_done(gen_done)
  );

  typedef struct packed {
    logic [NCH-1:0] pin;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } exp_t;

  typedef struct {
    int ch; int h; int l; int n; int done_k;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[7];
  int   m_act[NCH], m_s[NCH], m_h[NCH], m_l[NCH], m_n[NCH], m_e[NCH];
  int   last_done[NCH];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  string tag = "reset";

  // Expected outputs during cycle c (sampled just after edge c).
  function automatic void exp_at(input int ch, input int c,
                                 output logic p, output logic b, output logic d);
    int k, per;
    p = 1'b0; b = 1'b0; d = 1'b0;
    if (m_act[ch] == 0 || c >= m_e[ch] || c < m_s[ch]) return;
    k   = c - m_s[ch] + 1;
    per = m_h[ch] + m_l[ch];
    if (m_n[ch] != 0 && k > m_n[ch] * per) begin
      d = (k == m_n[ch] * per + 1);
      return;
    end
    b = 1'b1;
    p = ((k - 1) % per) < m_h[ch];
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    exp_t e, g;
    logic p, b, d;
    int h, l;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      h = int'(high_time[ch*TW +: TW]);
      l = int'(low_time[ch*TW +: TW]);
      if (!rst_n) begin
        m_act[ch] = 0;
      end else begin
        exp_at(ch, cyc - 1, p, b, d);
        if (gen_start[ch] && !gen_stop[ch] && !b && h != 0 && l != 0) begin
          m_act[ch] = 1; m_s[ch] = cyc; m_h[ch] = h; m_l[ch] = l;
          m_n[ch] = int'(pulse_count[ch*TW +: TW]); m_e[ch] = NEVER;
        end else if (gen_stop[ch] && b) begin
          m_e[ch] = cyc;
        end
      end
      exp_at(ch, cyc, p, b, d);
      e.pin[ch] = p; e.busy[ch] = b; e.done[ch] = d;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    g = {gen_pin, gen_busy, gen_done};
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: pin/busy/done got %h/%h/%h, expected %h/%h/%h",
               tag, cyc, g.pin, g.busy, g.done, e.pin, e.busy, e.done);
    end
    for (int ch = 0; ch < NCH; ch++)
      if (gen_done[ch] === 1'b1) last_done[ch] = cyc;
  endtask

  task automatic set_ch(input int ch, input int h, input int l, input int n);
    high_time[ch*TW +: TW]   = TW'(h);
    low_time[ch*TW +: TW]    = TW'(l);
    pulse_count[ch*TW +: TW] = TW'(n);
  endtask

  initial begin
    int s, len, got;
    tv[0] = '{ch: 0, h: 3, l: 2, n: 2, done_k: 11};
    tv[1] = '{ch: 2, h: 0, l: 5, n: 1, done_k: 0};
    tv[2] = '{ch: 2, h: 4, l: 0, n: 1, done_k: 0};
    tv[3] = '{ch: 2, h: 4, l: 4, n: 1, done_k: 9};
    tv[4] = '{ch: 4, h: 1, l: 3, n: 2, done_k: 9};
    tv[5] = '{ch: 6, h: 2, l: 1, n: 4, done_k: 13};
    tv[6] = '{ch: 7, h: 1, l: 1, n: 1, done_k: 3};
    for (int ch = 0; ch < NCH; ch++) begin
      m_act[ch] = 0; m_s[ch] = 0; m_h[ch] = 1; m_l[ch] = 1; m_n[ch] = 0;
      m_e[ch] = NEVER; last_done[ch] = 0;
    end
    rst_n = 1'b0; gen_start = '0; gen_stop = '0;
    high_time = '0; low_time = '0; pulse_count = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    tag = "table";
    for (int i = 0; i < 7; i++) begin
      set_ch(tv[i].ch, tv[i].h, tv[i].l, tv[i].n);
      last_done[tv[i].ch] = 0;
      gen_start[tv[i].ch] = 1'b1;
      s = cyc + 1;
      tick();
      gen_start = '0;
      len = (tv[i].done_k != 0) ? tv[i].done_k + 2 : 12;
      repeat (len - 1) tick();
      got = (last_done[tv[i].ch] != 0) ? last_done[tv[i].ch] - s + 1 : 0;
      check($sformatf("table%0d_done_cycle", i), got, tv[i].done_k);
    end

    tag = "continuous_stop";
    set_ch(1, 1, 1, 0);
    last_done[1] = 0;
    gen_start[1] = 1'b1;
    tick();
    gen_start = '0;
    repeat (19) tick();
    set_ch(1, 3, 3, 1);
    gen_start[1] = 1'b1;
    tick();
    gen_start = '0;
    repeat (29) tick();
    gen_stop[1] = 1'b1;
    tick();
    gen_stop = '0;
    repeat (5) tick();
    check("continuous_no_done", last_done[1], 0);

    tag = "latched_inputs";
    set_ch(3, 5, 5, 3);
    last_done[3] = 0;
    gen_start[3] = 1'b1;
    s = cyc + 1;
    tick();
    gen_start = '0;
    repeat (5) tick();
    set_ch(3, 1, 5, 3);
    gen_start[3] = 1'b1;
    tick();
    gen_start = '0;
    repeat (24) tick();
    got = (last_done[3] != 0) ? last_done[3] - s + 1 : 0;
    check("latched_done_cycle", got, 31);
    gen_start[3] = 1'b1;
    tick();
    gen_start = '0;
    repeat (20) tick();

    tag = "all_channels";
    for (int ch = 0; ch < NCH; ch++) begin
      set_ch(ch, ch + 1, 2, 2);
      last_done[ch] = 0;
    end
    gen_start = '1;
    s = cyc + 1;
    tick();
    gen_start = '0;
    repeat (24) tick();
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("all_ch%0d_done_cycle", ch), last_done[ch] - s + 1, 2 * (ch + 3) + 1);

    tag = "start_stop_together";
    set_ch(2, 3, 3, 1);
    gen_start[2] = 1'b1; gen_stop[2] = 1'b1;
    tick();
    gen_start = '0; gen_stop = '0;
    repeat (3) tick();

    tag = "reset_mid_run";
    set_ch(0, 4, 4, 0);
    set_ch(5, 2, 6, 0);
    gen_start[0] = 1'b1; gen_start[5] = 1'b1;
    tick();
    gen_start = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    set_ch(0, 3, 2, 2);
    last_done[0] = 0;
    gen_start[0] = 1'b1;
    s = cyc + 1;
    tick();
    gen_start = '0;
    repeat (12) tick();
    check("post_reset_done_cycle", last_done[0] - s + 1, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dsg_multichannel.md
Name: dsg_multichannel

Overview:
- Multichannel digital signal generator: each channel drives a square wave with programmed high and low durations, counted in clk cycles.
- Runs for a fixed number of periods, or continuously until stopped.
- Transmit-side counterpart of the multichannel high/low time measurement block, sharing the same per-channel 16-bit time encoding so measured values can be replayed directly.
- Sits in the logic subsystem alongside the measurement channels; controlled by the command layer.

Parameters:
- NUM_CHANNELS, 8, number of independent generator channels.
- TIME_W, 16, width of the high_time, low_time and pulse_count fields per channel.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- gen_start  input  NUM_CHANNELS  per-channel start request, sampled on the clk rising edge.
- gen_stop  input  NUM_CHANNELS  per-channel abort request.
- high_time  input  NUM_CHANNELS*TIME_W  per-channel high duration in cycles; ch packed at [(ch+1)*TIME_W-1 : ch*TIME_W].
- low_time  input  NUM_CHANNELS*TIME_W  per-channel low duration in cycles; same packing.
- pulse_count  input  NUM_CHANNELS*TIME_W  per-channel number of periods; 0 = continuous.
- gen_pin  output  NUM_CHANNELS  generated waveform, registered.
- gen_busy  output  NUM_CHANNELS  channel is generating.
- gen_done  output  NUM_CHANNELS  one-cycle pulse on normal completion.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is synchronous and active-low. All state changes only on the clk rising edge.
- Reset (synchronous, rst_n=0 at an edge):
  - All channels go to IDLE.
  - gen_pin=0, gen_busy=0, gen_done=0; internal counters and latched values cleared.
  - Applies mid-operation with no completion pulse.
- Per-channel FSM states:
  - IDLE: pin low, busy=0.
  - HIGH: pin high.
  - LOW: pin low.
- Start acceptance: gen_start=1 in IDLE, gen_stop=0, high_time≠0 and low_time≠0.
  - Latch H, L, N at that edge.
  - Next state is HIGH.
  - Start with H=0 or L=0 is ignored: stay IDLE, no busy, no done.
- Timing, with start sampled at edge T:
  - gen_pin=1 and gen_busy=1 during cycles T+1 … T+H.
  - gen_pin=0 during cycles T+H+1 … T+H+L.
  - Period = H+L cycles, repeating.
- Period counting:
  - A period completes at the last LOW cycle; the completed-period counter increments there.
  - When completed == N and N≠0: next state IDLE.
  - At cycle T+N(H+L)+1: gen_pin=0, gen_busy=0, gen_done=1 for exactly one cycle.
- N=0: continuous operation; counter is not compared; runs until gen_stop or reset.
- Down-counter per phase: loaded with H-1 on entering HIGH and L-1 on entering LOW; phase ends when the counter equals 0.
- Maximum values: H=L=65535 supported without wrap errors. Period counter is TIME_W bits and does not saturate-wrap incorrectly, since the compare occurs before increment overflow.
- Inputs are latched: changes to high_time, low_time or pulse_count while busy have no effect until the next accepted start.
- gen_start while busy: ignored (no restart).
- gen_stop while busy: next cycle IDLE, pin=0, busy=0, gen_done stays 0.
- gen_start and gen_stop together: stop wins; start is not accepted.
- Back-to-back runs: a start asserted in the same cycle as gen_done (state IDLE) is accepted; pin rises the following cycle.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Shared package dsg_pkg:
  - typedef dsg_state_t enum {IDLE, HIGH, LOW}.
  - Localparam TIME_W_DEFAULT = 16, shared with the measurement side.
- Sub-module digital_signal_generate implements one channel: FSM, phase counter, period counter.
- dsg_multichannel contains only a generate loop that slices the packed inputs per channel and instantiates one digital_signal_generate per channel.

Test Plan:
- ch0 H=3 L=2 N=2, start at edge T -> gen_pin over T+1..T+10 = 1,1,1,0,0,1,1,1,0,0; busy high T+1..T+10; done=1 only at T+11; busy=0 at T+11.
- ch1 H=1 L=1 N=0 -> toggles 1,0 every cycle for 100+ cycles, done never asserted; gen_stop at cycle 50 -> pin=0, busy=0 next cycle, no done.
- ch2 start with H=0, L=5 -> busy, pin and done all stay 0; then H=4 L=0 -> same; then H=4 L=4 N=1 -> 8-cycle period, done at T+9.
- ch3 H=5 L=5 N=3 running; change inputs to H=1 and pulse start at cycle 7 -> waveform unchanged, exactly 3 periods, done at T+31; start in the done cycle -> new run with H=1 begins the next cycle.
- All 8 channels started on the same edge with H=ch+1, L=2, N=2 -> each pin matches its independent pattern; done pulses at T+2(ch+3)+1.
- rst_n=0 for one edge mid-HIGH on ch0 and mid-LOW on ch5 -> next cycle all pin/busy/done=0; a subsequent start behaves as from power-up.
